// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks E0/F0 prefixes, reports make/break events,
// and holds the last-made key with its uppercase ASCII translation.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [7:0]       code,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ev_valid,
  output logic             ev_make,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t state;
  logic   tgt_ext;
  logic   same_key;
  logic   repeat_hit;

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic e);
    logic [7:0] a;
    a = 8'h00;
    if (!e) begin
      case (c)
        8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
        8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
        8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
        8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
        8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
        8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
        8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  // A byte targets the extended key set whenever an E0 prefix is pending.
  always_comb begin
    tgt_ext    = (state == EXT) || (state == EXT_BRK);
    same_key   = (key_code == code) && (key_ext == tgt_ext);
    repeat_hit = key_down && same_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_down  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_ascii <= 8'h00;
      press_cnt <= '0;
      ev_valid  <= 1'b0;
      ev_make   <= 1'b0;
      err       <= 1'b0;
    end else begin
      ev_valid <= 1'b0;
      err      <= 1'b0;
      if (code_valid) begin
        case (state)
          IDLE, EXT: begin
            if (code == 8'hE0) begin
              state <= EXT;
            end else if (code == 8'hF0) begin
              state <= (state == IDLE) ? BRK : EXT_BRK;
            end else begin
              state <= IDLE;
              // Typematic repeats of the held key produce no event.
              if (!repeat_hit) begin
                key_down  <= 1'b1;
                key_code  <= code;
                key_ext   <= tgt_ext;
                key_ascii <= ascii_of(code, tgt_ext);
                press_cnt <= press_cnt + CNT_W'(1);
                ev_valid  <= 1'b1;
                ev_make   <= 1'b1;
              end
            end
          end
          BRK, EXT_BRK: begin
            state <= IDLE;
            if (code == 8'hE0 || code == 8'hF0) begin
              err <= 1'b1;
            end else begin
              ev_valid <= 1'b1;
              ev_make  <= 1'b0;
              if (same_key) key_down <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
